// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-serialising data-memory word master:
// request size encodings, FSM states and default bus widths.
package dmem_pkg;

  localparam int unsigned DMEM_ADDRWIDTH = 17;
  localparam int unsigned DMEM_DATAWIDTH = 8;
  localparam int unsigned DMEM_WORDWIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } req_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Byte count of a request; the reserved encoding behaves as a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (req_size_e'(size))
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_word_master_if.sv
// Request/response handshake plus byte-wide memory port A of the word master.
interface dmem_word_master_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = DMEM_ADDRWIDTH,
  parameter int unsigned DATAWIDTH = DMEM_DATAWIDTH,
  parameter int unsigned WORDWIDTH = DMEM_WORDWIDTH
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic [ADDRWIDTH-1:0] req_addr;
  logic [WORDWIDTH-1:0] req_wdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORDWIDTH-1:0] rsp_rdata;

  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_din;
  logic                 mem_we;
  logic [DATAWIDTH-1:0] mem_dout;

  // The word master drives the memory port and answers requests.
  modport master (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_din, mem_we
  );

  modport slave (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/dmem_word_master.sv
// Splits byte/half/word loads and stores into sequential single-byte accesses
// on a synchronous-read byte memory, with wrap-around addressing.
module dmem_word_master
  import dmem_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = DMEM_ADDRWIDTH,
  parameter int unsigned DATAWIDTH = DMEM_DATAWIDTH,
  parameter int unsigned WORDWIDTH = DMEM_WORDWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  dmem_word_master_if.master bus
);

  localparam int unsigned LANES = WORDWIDTH / DATAWIDTH;
  localparam int unsigned CNTW  = $clog2(LANES + 1);
  localparam int unsigned LANEW = (LANES > 1) ? $clog2(LANES) : 1;

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [CNTW-1:0]      n_q, n_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [WORDWIDTH-1:0] wdata_q, wdata_d;

  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORDWIDTH-1:0] rdata_q, rdata_d;
  logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATAWIDTH-1:0] mem_din_q, mem_din_d;
  logic                 mem_we_q, mem_we_d;

  logic                 accept;
  logic [LANEW-1:0]     wr_lane;
  logic [LANEW-1:0]     rd_lane;

  assign accept = req_ready_q && bus.req_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: READ spans N+1 cycles to collect the last byte, WRITE spans N
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = bus.req_we ? ST_WRITE : ST_READ;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        if (cnt_q == n_q) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_q == n_q - CNTW'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state/count
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    n_d         = n_q;
    rdata_d     = rdata_q;
    mem_addr_d  = '0;
    mem_din_d   = '0;
    mem_we_d    = 1'b0;
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    wr_lane     = LANEW'(cnt_d);
    rd_lane     = LANEW'(cnt_q - CNTW'(1));

    if (accept) begin
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      n_d     = CNTW'(size_to_bytes(bus.req_size));
      rdata_d = '0;
    end

    // mem_dout in read cycle k belongs to the byte issued in cycle k-1
    if (state_q == ST_READ && cnt_q != '0) begin
      rdata_d[int'(rd_lane)*DATAWIDTH +: DATAWIDTH] = bus.mem_dout;
    end

    if (state_d == ST_IDLE) rdata_d = '0;

    if (state_d == ST_WRITE) begin
      mem_we_d   = 1'b1;
      mem_addr_d = addr_d + ADDRWIDTH'(cnt_d);
      mem_din_d  = wdata_d[int'(wr_lane)*DATAWIDTH +: DATAWIDTH];
    end else if (state_d == ST_READ && cnt_d != n_d) begin
      mem_addr_d = addr_d + ADDRWIDTH'(cnt_d);
    end
  end

  // Output and latched-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      n_q         <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      n_q         <= n_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_dmem_word_master.sv
// Directed bench for dmem_word_master with a byte memory model on port A
// (byte k initialised to k mod 256) and a response scoreboard.
module tb_dmem_word_master;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_word_master_if bus ();

  dmem_word_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read byte memory, port A
  logic [7:0]  mem [0:(1<<17)-1];
  logic [16:0] mem_areg = '0;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    mem_areg <= bus.mem_addr;
  end

  assign bus.mem_dout = mem[mem_areg];

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] peek4(input logic [16:0] a);
    return {mem[a + 17'd3], mem[a + 17'd2], mem[a + 17'd1], mem[a]};
  endfunction

  // One full request/response, starting and ending at a negedge with the DUT idle
  task automatic txn(input string tag, input logic we, input logic [1:0] size,
                     input logic [16:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp, input int hold);
    int nb;
    int cyc;
    int we_cnt;
    logic [31:0] snap;
    logic [31:0] want;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    sb_q.push_back(exp);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = '0;
    bus.req_addr  = '0;
    cyc    = 1;
    we_cnt = 0;
    check({tag, "/first_addr"}, 32'(bus.mem_addr), 32'(addr));
    if (we) check({tag, "/first_din"}, 32'(bus.mem_din), 32'(wdata[7:0]));
    while (!bus.rsp_valid && cyc < 20) begin
      we_cnt += int'(bus.mem_we);
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 32'(cyc), we ? 32'(nb + 1) : 32'(nb + 2));
    check({tag, "/we_cycles"}, 32'(we_cnt), we ? 32'(nb) : 32'd0);
    snap = bus.rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      check({tag, "/hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "/hold_rdata"}, bus.rsp_rdata, snap);
      check({tag, "/hold_ready"}, 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    check({tag, "/resp_bus_idle"}, 32'({bus.mem_we, bus.mem_addr, bus.mem_din}), 32'd0);
    bus.rsp_ready = 1'b1;
    want = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "/rdata"}, bus.rsp_rdata, want);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "/released"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int seen_valid;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < (1 << 17); k++) mem[k] <= 8'(k);

    @(negedge clk);
    @(negedge clk);
    check("reset/req_ready", 32'(bus.req_ready), 32'd1);
    check("reset/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset/rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset/mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_din}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    txn("ld_w_10",   1'b0, 2'b10, 17'h00010, 32'h0, 32'h1312_1110, 0);
    txn("st_w_20",   1'b1, 2'b10, 17'h00020, 32'hDEAD_BEEF, 32'h0, 0);
    check("st_w_20/mem", peek4(17'h00020), 32'hDEAD_BEEF);
    txn("ld_w_20",   1'b0, 2'b10, 17'h00020, 32'h0, 32'hDEAD_BEEF, 0);
    txn("ld_b_top",  1'b0, 2'b00, 17'h1FFFF, 32'h0, 32'h0000_00FF, 0);
    txn("ld_w_wrap", 1'b0, 2'b10, 17'h1FFFE, 32'h0, 32'h0100_FFFE, 0);
    txn("st_h_31",   1'b1, 2'b01, 17'h00031, 32'h5A5A_A5A5, 32'h0, 0);
    check("st_h_31/mem", peek4(17'h00030), 32'h33A5_A530);
    txn("ld_h_31",   1'b0, 2'b01, 17'h00031, 32'h0, 32'h0000_A5A5, 3);
    txn("ld_rsvd",   1'b0, 2'b11, 17'h00004, 32'h0, 32'h0706_0504, 1);

    // Reset during the third byte of a word store
    check("rst_st/req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 17'h00040;
    bus.req_wdata = 32'h1122_3344;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_st/we_before", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_st/mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_din}), 32'd0);
    check("rst_st/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_st/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    repeat (6) begin
      @(negedge clk);
      seen_valid += int'(bus.rsp_valid);
    end
    check("rst_st/no_rsp", 32'(seen_valid), 32'd0);
    check("rst_st/mem", peek4(17'h00040), 32'h4342_3344);
    txn("ld_w_40",   1'b0, 2'b10, 17'h00040, 32'h0, 32'h4342_3344, 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
